// File: rtl/mc_control_fsm.sv
// mc_control_fsm -- multicycle control unit for a MIPS-style datapath
// (PC, memory, IR, MDR, register file, A/B, ALU, ALU-out register).
//
// Adds the following to the classic multicycle control:
//   - a variable-latency memory handshake with an optional timeout,
//   - optional BNE and ADDI decode,
//   - sticky illegal-opcode and bus-error flags,
//   - retired-instruction and active-cycle counters.
//
// Ports
//   clk, rst       : clock; synchronous active-high reset
//   opcode         : IR[31:26]
//   mem_ready      : memory completes the current access this cycle
//   mem_req        : high throughout every memory state
//   PCWrite .. BranchNE, ALUSrcB, ALUOp, PCSource : datapath control bus
//   state          : current state encoding (debug)
//   illegal_op     : sticky, an unsupported opcode was decoded
//   bus_error      : sticky, a memory access timed out
//   instr_count    : retired instructions (wraps)
//   cycle_count    : non-reset, non-ERR cycles (wraps)
module mc_control_fsm #(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned TIMEOUT     = 16,
  parameter bit          ENABLE_BNE  = 1'b1,
  parameter bit          ENABLE_ADDI = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             PCWrite,
  output logic             IorD,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             ALUSrcA,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             RegDst,
  output logic             PCWriteCond,
  output logic             MemRead,
  output logic             Branch,
  output logic             BranchNE,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic [3:0]       state,
  output logic             illegal_op,
  output logic             bus_error,
  output logic [CNT_W-1:0] instr_count,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int unsigned WAIT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXEC    = 4'd6,
    RWB     = 4'd7,
    BRANCH  = 4'd8,
    JUMP    = 4'd9,
    ADDI_EX = 4'd10,
    ADDI_WB = 4'd11,
    ERR     = 4'd12
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [WAIT_W-1:0] r_wait;
  logic [CNT_W-1:0]  r_instr;
  logic [CNT_W-1:0]  r_cycle;
  logic              r_illegal;
  logic              r_bus_err;
  logic              w_mem_state;
  logic              w_timeout;
  logic              w_set_illegal;
  logic              w_set_bus;
  logic              w_retire;

  assign w_timeout = (TIMEOUT != 0) && (r_wait == WAIT_W'(TIMEOUT));
  // Every transition into FETCH from a non-memory-wait, non-ERR state retires
  // an instruction; FETCH->FETCH is a wait and ERR only leaves through reset.
  assign w_retire  = (w_next == FETCH) && (r_state != FETCH) && (r_state != ERR);

  always_comb begin
    w_next        = r_state;
    w_set_illegal = 1'b0;
    w_set_bus     = 1'b0;
    w_mem_state   = 1'b0;
    mem_req       = 1'b0;
    PCWrite       = 1'b0;
    IorD          = 1'b0;
    MemWrite      = 1'b0;
    IRWrite       = 1'b0;
    ALUSrcA       = 1'b0;
    MemtoReg      = 1'b0;
    RegWrite      = 1'b0;
    RegDst        = 1'b0;
    PCWriteCond   = 1'b0;
    MemRead       = 1'b0;
    Branch        = 1'b0;
    BranchNE      = 1'b0;
    ALUSrcB       = '0;
    ALUOp         = '0;
    PCSource      = '0;

    case (r_state)
      FETCH: begin
        w_mem_state = 1'b1;
        mem_req     = 1'b1;
        MemRead     = 1'b1;
        ALUSrcB     = 2'b01;
        IRWrite     = mem_ready;
        PCWrite     = mem_ready;
        if (mem_ready) w_next = DECODE;
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        case (opcode)
          6'h00:        w_next = EXEC;
          6'h23, 6'h2B: w_next = MEMADR;
          6'h04:        w_next = BRANCH;
          6'h02:        w_next = JUMP;
          6'h05: begin
            w_next        = ENABLE_BNE ? BRANCH : ERR;
            w_set_illegal = !ENABLE_BNE;
          end
          6'h08: begin
            w_next        = ENABLE_ADDI ? ADDI_EX : ERR;
            w_set_illegal = !ENABLE_ADDI;
          end
          default: begin
            w_next        = ERR;
            w_set_illegal = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        w_next  = (opcode == 6'h23) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        w_mem_state = 1'b1;
        mem_req     = 1'b1;
        MemRead     = 1'b1;
        IorD        = 1'b1;
        if (mem_ready) w_next = MEMWB;
      end
      MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        w_next   = FETCH;
      end
      MEMWR: begin
        w_mem_state = 1'b1;
        mem_req     = 1'b1;
        MemWrite    = 1'b1;
        IorD        = 1'b1;
        if (mem_ready) w_next = FETCH;
      end
      EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
        w_next  = RWB;
      end
      RWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
        w_next   = FETCH;
      end
      BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        Branch      = (opcode == 6'h04);
        BranchNE    = (opcode == 6'h05);
        w_next      = FETCH;
      end
      JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
        w_next   = FETCH;
      end
      ADDI_EX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        w_next  = ADDI_WB;
      end
      ADDI_WB: begin
        RegWrite = 1'b1;
        w_next   = FETCH;
      end
      ERR:     w_next = ERR;
      default: w_next = FETCH;
    endcase

    // Shared timeout for all memory states; mem_ready at the limit wins.
    if (w_mem_state && !mem_ready && w_timeout) begin
      w_next    = ERR;
      w_set_bus = 1'b1;
    end

    if (rst) begin
      mem_req     = 1'b0;
      PCWrite     = 1'b0;
      IorD        = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      ALUSrcA     = 1'b0;
      MemtoReg    = 1'b0;
      RegWrite    = 1'b0;
      RegDst      = 1'b0;
      PCWriteCond = 1'b0;
      MemRead     = 1'b0;
      Branch      = 1'b0;
      BranchNE    = 1'b0;
      ALUSrcB     = '0;
      ALUOp       = '0;
      PCSource    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= FETCH;
      r_wait    <= '0;
      r_instr   <= '0;
      r_cycle   <= '0;
      r_illegal <= 1'b0;
      r_bus_err <= 1'b0;
    end else begin
      r_state <= w_next;
      // Counting only while staying in the same memory state also covers
      // the clear-on-entry and clear-on-ready cases.
      if (w_mem_state && !mem_ready && (w_next == r_state) && (TIMEOUT != 0))
        r_wait <= r_wait + 1'b1;
      else
        r_wait <= '0;
      if (r_state != ERR) r_cycle <= r_cycle + 1'b1;
      if (w_retire)       r_instr <= r_instr + 1'b1;
      if (w_set_illegal)  r_illegal <= 1'b1;
      if (w_set_bus)      r_bus_err <= 1'b1;
    end
  end

  assign state       = r_state;
  assign illegal_op  = r_illegal;
  assign bus_error   = r_bus_err;
  assign instr_count = r_instr;
  assign cycle_count = r_cycle;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm. Instance 0 uses default parameters; instance 1
// uses CNT_W=4, TIMEOUT=4 with BNE and ADDI disabled. Each instance has its
// own inputs and its own instruction-level reference model.
module tb_mc_control_fsm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_i [2];
  logic [5:0]  op_i  [2];
  logic        rdy_i [2];
  logic [18:0] ctl_o [2];
  logic        ill_o [2];
  logic        bus_o [2];
  logic [31:0] ic_o  [2];
  logic [31:0] cc_o  [2];

  // Control word: {mem_req, PCWrite, IorD, MemWrite, IRWrite, ALUSrcA,
  // MemtoReg, RegWrite, RegDst, PCWriteCond, MemRead, Branch, BranchNE,
  // ALUSrcB[1:0], ALUOp[1:0], PCSource[1:0]}
  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int unsigned CW = (g == 0) ? 32 : 4;
    localparam int unsigned TO = (g == 0) ? 16 : 4;
    localparam bit          EN = (g == 0);
    logic mreq, pcw, iord, mw, irw, asa, m2r, rw, rd, pwc, mr, br, bne;
    logic [1:0] asb, aop, pcs;
    logic [3:0] st;
    logic [CW-1:0] ic, cc;
    mc_control_fsm #(.CNT_W(CW), .TIMEOUT(TO), .ENABLE_BNE(EN), .ENABLE_ADDI(EN)) u_dut (
      .clk(clk), .rst(rst_i[g]), .opcode(op_i[g]), .mem_ready(rdy_i[g]),
      .mem_req(mreq), .PCWrite(pcw), .IorD(iord), .MemWrite(mw), .IRWrite(irw),
      .ALUSrcA(asa), .MemtoReg(m2r), .RegWrite(rw), .RegDst(rd),
      .PCWriteCond(pwc), .MemRead(mr), .Branch(br), .BranchNE(bne),
      .ALUSrcB(asb), .ALUOp(aop), .PCSource(pcs), .state(st),
      .illegal_op(ill_o[g]), .bus_error(bus_o[g]),
      .instr_count(ic), .cycle_count(cc)
    );
    assign ctl_o[g] = {mreq, pcw, iord, mw, irw, asa, m2r, rw, rd, pwc, mr, br, bne, asb, aop, pcs};
    assign ic_o[g]  = 32'(ic);
    assign cc_o[g]  = 32'(cc);
  end

  // ---------------- reference model ----------------
  typedef enum {P_FETCH, P_DEC, P_ADR, P_RD, P_MWB, P_WR, P_EX, P_RWB,
                P_BR, P_J, P_AEX, P_AWB, P_ERR} ph_t;

  int unsigned cw_m [2] = '{32, 4};
  int unsigned to_m [2] = '{16, 4};
  bit          en_m [2] = '{1'b1, 1'b0};

  ph_t         ph  [2];
  int unsigned wt  [2];
  logic [31:0] ic  [2];
  logic [31:0] cc  [2];
  bit          ill [2];
  bit          bus [2];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  function automatic logic [31:0] wrap(logic [31:0] v, int unsigned w);
    return (w >= 32) ? v : (v & ((32'd1 << w) - 32'd1));
  endfunction

  function automatic ph_t dec_target(logic [5:0] op, int m);
    case (op)
      6'h00:        return P_EX;
      6'h23, 6'h2B: return P_ADR;
      6'h04:        return P_BR;
      6'h05:        return en_m[m] ? P_BR : P_ERR;
      6'h02:        return P_J;
      6'h08:        return en_m[m] ? P_AEX : P_ERR;
      default:      return P_ERR;
    endcase
  endfunction

  function automatic logic [18:0] exp_ctrl(ph_t p, logic [5:0] op, logic rdy);
    logic mreq, pcw, iord, mw, irw, asa, m2r, rw, rd, pwc, mr, br, bne;
    logic [1:0] asb, aop, pcs;
    {mreq, pcw, iord, mw, irw, asa, m2r, rw, rd, pwc, mr, br, bne} = '0;
    asb = '0; aop = '0; pcs = '0;
    case (p)
      P_FETCH: begin mreq = 1; mr = 1; asb = 2'b01; irw = rdy; pcw = rdy; end
      P_DEC:   asb = 2'b11;
      P_ADR:   begin asa = 1; asb = 2'b10; end
      P_RD:    begin mreq = 1; mr = 1; iord = 1; end
      P_MWB:   begin rw = 1; m2r = 1; end
      P_WR:    begin mreq = 1; mw = 1; iord = 1; end
      P_EX:    begin asa = 1; aop = 2'b10; end
      P_RWB:   begin rd = 1; rw = 1; end
      P_BR:    begin asa = 1; aop = 2'b01; pwc = 1; pcs = 2'b01;
                     br = (op == 6'h04); bne = (op == 6'h05); end
      P_J:     begin pcw = 1; pcs = 2'b10; end
      P_AEX:   begin asa = 1; asb = 2'b10; end
      P_AWB:   rw = 1;
      default: ;
    endcase
    return {mreq, pcw, iord, mw, irw, asa, m2r, rw, rd, pwc, mr, br, bne, asb, aop, pcs};
  endfunction

  task automatic model_step(int m);
    ph_t nxt;
    if (rst_i[m]) begin
      ph[m] = P_FETCH; wt[m] = 0; ic[m] = 0; cc[m] = 0; ill[m] = 0; bus[m] = 0;
      return;
    end
    nxt = ph[m];
    if (ph[m] != P_ERR) cc[m] = wrap(cc[m] + 1, cw_m[m]);
    if (ph[m] == P_FETCH || ph[m] == P_RD || ph[m] == P_WR) begin
      if (rdy_i[m])
        nxt = (ph[m] == P_FETCH) ? P_DEC : (ph[m] == P_RD) ? P_MWB : P_FETCH;
      else if (to_m[m] > 0 && wt[m] == to_m[m]) begin
        nxt = P_ERR; bus[m] = 1;
      end else
        wt[m]++;
    end else begin
      case (ph[m])
        P_DEC: begin nxt = dec_target(op_i[m], m); if (nxt == P_ERR) ill[m] = 1; end
        P_ADR: nxt = (op_i[m] == 6'h23) ? P_RD : P_WR;
        P_EX:  nxt = P_RWB;
        P_AEX: nxt = P_AWB;
        P_ERR: nxt = P_ERR;
        default: nxt = P_FETCH;
      endcase
    end
    if (nxt == P_FETCH && ph[m] != P_FETCH) ic[m] = wrap(ic[m] + 1, cw_m[m]);
    if (nxt != ph[m]) wt[m] = 0;
    ph[m] = nxt;
  endtask

  // ---------------- comparison ----------------
  task automatic cmp(string name, int m, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d cycle %0d: got %h expected %h", name, m, cyc, act, exp);
    end
  endtask

  task automatic check(int m);
    logic [18:0] e;
    e = rst_i[m] ? 19'd0 : exp_ctrl(ph[m], op_i[m], rdy_i[m]);
    cmp("ctrl", m, 32'(ctl_o[m]), 32'(e));
    cmp("illegal_op", m, 32'(ill_o[m]), 32'(ill[m]));
    cmp("bus_error", m, 32'(bus_o[m]), 32'(bus[m]));
    cmp("instr_count", m, ic_o[m], ic[m]);
    cmp("cycle_count", m, cc_o[m], cc[m]);
  endtask

  // Inputs are set just after a falling edge; outputs are checked 1ns later.
  task automatic tick();
    #1;
    check(0);
    check(1);
    @(posedge clk);
    model_step(0);
    model_step(1);
    cyc++;
    @(negedge clk);
  endtask

  task automatic drive(int m, logic r, logic [5:0] op, logic rdy);
    rst_i[m] = r; op_i[m] = op; rdy_i[m] = rdy;
  endtask

  task automatic reset_all();
    drive(0, 1, 6'h00, 0);
    drive(1, 1, 6'h00, 0);
    tick();
    tick();
  endtask

  function automatic logic [5:0] pick_op();
    logic [5:0] tbl [8];
    int unsigned r;
    tbl = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h08, 6'h3F};
    r = $urandom_range(0, 9);
    return (r < 8) ? tbl[r] : 6'($urandom_range(0, 63));
  endfunction

  initial begin
    int irw_cnt;
    bit slow [2];
    for (int m = 0; m < 2; m++) begin
      ph[m] = P_FETCH; wt[m] = 0; ic[m] = 0; cc[m] = 0; ill[m] = 0; bus[m] = 0;
    end
    drive(0, 1, 6'h00, 0);
    drive(1, 1, 6'h00, 0);
    @(negedge clk);
    reset_all();
    cmp("reset_instr", 0, ic_o[0], 32'd0);
    cmp("reset_ctrl", 0, 32'(ctl_o[0]), 32'd0);

    // R-type, always ready: 4 cycles per instruction
    for (int i = 0; i < 4; i++) begin drive(0, 0, 6'h00, 1); tick(); end
    cmp("rtype_instr", 0, ic_o[0], 32'd1);
    cmp("rtype_cycles", 0, cc_o[0], 32'd4);

    // LW with 3 wait cycles in FETCH and in MEMRD: 11 cycles
    reset_all();
    irw_cnt = 0;
    for (int i = 0; i < 11; i++) begin
      drive(0, 0, 6'h23, !(i inside {0, 1, 2, 6, 7, 8}));
      #1;
      if (ctl_o[0][14]) irw_cnt++;
      tick();
    end
    cmp("lw_irwrite_pulses", 0, 32'(irw_cnt), 32'd1);
    cmp("lw_cycles", 0, cc_o[0], 32'd11);
    cmp("lw_instr", 0, ic_o[0], 32'd1);

    // BEQ then BNE
    reset_all();
    for (int i = 0; i < 3; i++) begin drive(0, 0, 6'h04, 1); tick(); end
    for (int i = 0; i < 2; i++) begin drive(0, 0, 6'h05, 1); tick(); end
    #1;
    cmp("bne_branch_bits", 0, 32'(ctl_o[0][7:6]), 32'd1);
    cmp("bne_pcsource", 0, 32'(ctl_o[0][1:0]), 32'd1);
    tick();
    cmp("branch_instr", 0, ic_o[0], 32'd2);

    // BNE disabled on instance 1 -> illegal
    reset_all();
    drive(0, 1, 6'h00, 0);
    for (int i = 0; i < 3; i++) begin drive(1, 0, 6'h05, 1); tick(); end
    cmp("bne_off_illegal", 1, 32'(ill_o[1]), 32'd1);
    cmp("bne_off_instr", 1, ic_o[1], 32'd0);

    // Timeout in MEMWR, then mem_ready exactly at the limit
    reset_all();
    for (int i = 0; i < 11; i++) begin drive(1, 0, 6'h2B, i < 3); tick(); end
    cmp("timeout_bus_error", 1, 32'(bus_o[1]), 32'd1);
    cmp("timeout_cycles_frozen", 1, cc_o[1], 32'd8);
    reset_all();
    for (int i = 0; i < 8; i++) begin drive(1, 0, 6'h2B, (i < 3) || (i == 7)); tick(); end
    cmp("limit_ready_bus_error", 1, 32'(bus_o[1]), 32'd0);
    cmp("limit_ready_instr", 1, ic_o[1], 32'd1);

    // Illegal opcode then a 1-cycle reset
    reset_all();
    drive(1, 1, 6'h00, 0);
    for (int i = 0; i < 3; i++) begin drive(0, 0, 6'h3F, 1); tick(); end
    #1;
    cmp("err_ctrl_zero", 0, 32'(ctl_o[0]), 32'd0);
    cmp("err_illegal", 0, 32'(ill_o[0]), 32'd1);
    tick();
    drive(0, 1, 6'h3F, 1);
    tick();
    drive(0, 0, 6'h00, 0);
    #1;
    cmp("post_rst_illegal", 0, 32'(ill_o[0]), 32'd0);
    cmp("post_rst_cycles", 0, cc_o[0], 32'd0);

    // 16 jumps on the 4-bit counter instance: wraps 15 -> 0
    reset_all();
    drive(0, 1, 6'h00, 0);
    for (int i = 0; i < 45; i++) begin drive(1, 0, 6'h02, 1); tick(); end
    cmp("jump_instr_15", 1, ic_o[1], 32'd15);
    for (int i = 0; i < 3; i++) begin drive(1, 0, 6'h02, 1); tick(); end
    cmp("jump_instr_wrap", 1, ic_o[1], 32'd0);

    // Randomized traffic on both instances
    reset_all();
    slow[0] = 0; slow[1] = 0;
    for (int i = 0; i < 4000; i++) begin
      for (int m = 0; m < 2; m++) begin
        if ($urandom_range(0, 49) == 0) slow[m] = !slow[m];
        rst_i[m] = (ph[m] == P_ERR) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 299) == 0);
        if (ph[m] == P_FETCH) op_i[m] = pick_op();
        rdy_i[m] = slow[m] ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 2) != 0);
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
